// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store bus adapter with lane steering and load extension
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  WL,
    input  logic        extendSign,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [3:0]  memBe,
    output logic [31:0] memWdata,
    input  logic [31:0] memRdata,
    input  logic        memAck
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state, state_nx;
    logic [1:0] lo_q, wl_q;
    logic sext_q, we_q;
    logic access, aligned, start;
    logic [3:0] be;
    logic [31:0] wd, ld;
    logic [7:0] b;
    logic [15:0] h;
    always_comb begin
        access = memRead | memWrite;
        aligned = (WL == 2'd0) || (WL == 2'd1 && !addr[0]) || (WL[1] && addr[1:0] == 2'd0);
        start = state == IDLE && access && aligned;
        state_nx = state == IDLE ? (start ? REQ : IDLE) :
                   state == REQ  ? (memAck ? DONE : REQ) : IDLE;
        stall = start || state == REQ;
        memReq = state == REQ;
        memWe = state == REQ && we_q;
        be = !memWrite ? 4'hf :
             WL == 2'd0 ? 4'b0001 << addr[1:0] :
             WL == 2'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'hf;
        wd = WL == 2'd0 ? {4{wdata[7:0]}} : WL == 2'd1 ? {2{wdata[15:0]}} : wdata;
        b = 8'(memRdata >> {lo_q, 3'b000});
        h = 16'(memRdata >> {lo_q[1], 4'b0000});
        ld = wl_q == 2'd0 ? {{24{sext_q & b[7]}}, b} :
             wl_q == 2'd1 ? {{16{sext_q & h[15]}}, h} : memRdata;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            misalign <= 1'b0;
            rdata <= '0;
            memAddr <= '0;
            memBe <= '0;
            memWdata <= '0;
            lo_q <= '0;
            wl_q <= '0;
            sext_q <= 1'b0;
            we_q <= 1'b0;
        end else begin
            state <= state_nx;
            misalign <= state == IDLE && access && !aligned;
            // bus outputs are captured once and held for the whole REQ phase
            if (start) begin
                memAddr <= {addr[31:2], 2'b00};
                memBe <= be;
                memWdata <= wd;
                lo_q <= addr[1:0];
                wl_q <= WL;
                sext_q <= extendSign;
                we_q <= memWrite;
            end
            if (state == REQ && memAck && !we_q)
                rdata <= ld;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks against a transaction-level model
module tb_load_store_unit;
    logic clk = 0, rst_n = 0, memRead = 0, memWrite = 0, extendSign = 0, memAck = 0;
    logic [1:0] WL = 0;
    logic [31:0] addr = 0, wdata = 0, memRdata = 0;
    logic [31:0] rdata, memAddr, memWdata;
    logic [3:0] memBe;
    logic stall, misalign, memReq, memWe;
    int n_chk = 0, n_err = 0;
    logic [31:0] exp_rdata = 0;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite), .WL(WL),
        .extendSign(extendSign), .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
        .misalign(misalign), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
        .memBe(memBe), .memWdata(memWdata), .memRdata(memRdata), .memAck(memAck)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] load_val(input int wl, input bit sext, input int lo, input logic [31:0] w);
        logic [31:0] v;
        if (wl == 0) begin
            v = (w >> (8 * lo)) & 32'hFF;
            if (sext && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (wl == 1) begin
            v = (w >> (16 * (lo / 2))) & 32'hFFFF;
            if (sext && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else v = w;
        return v;
    endfunction

    task automatic access(input bit rd, input bit wr, input int wl, input bit sext,
                          input logic [31:0] a, input logic [31:0] wd, input int waits,
                          input logic [31:0] rdw);
        int lo;
        bit al;
        logic [3:0] ebe;
        logic [31:0] ewd;
        lo = int'(a % 4);
        al = wl == 0 || (wl == 1 && lo % 2 == 0) || lo == 0;
        memRead = rd; memWrite = wr; WL = 2'(wl); extendSign = sext; addr = a; wdata = wd;
        #1;
        chk("stall_issue", {31'd0, stall}, {31'd0, al && (rd || wr)});
        tick();
        memRead = 0; memWrite = 0;
        if (!(rd || wr)) begin
            chk("idle_req", {31'd0, memReq}, 0);
            chk("idle_misalign", {31'd0, misalign}, 0);
            return;
        end
        if (!al) begin
            chk("mis_flag", {31'd0, misalign}, 1);
            chk("mis_req", {31'd0, memReq}, 0);
            chk("mis_stall", {31'd0, stall}, 0);
            tick();
            chk("mis_clear", {31'd0, misalign}, 0);
            chk("mis_req2", {31'd0, memReq}, 0);
            return;
        end
        ebe = !wr ? 4'hF : wl == 0 ? 4'(1 << lo) : wl == 1 ? 4'(3 << (lo / 2 * 2)) : 4'hF;
        ewd = wl == 0 ? (wd & 32'hFF) * 32'h01010101 : wl == 1 ? (wd & 32'hFFFF) * 32'h00010001 : wd;
        for (int i = 0; i <= waits; i++) begin
            chk("req_req", {31'd0, memReq}, 1);
            chk("req_stall", {31'd0, stall}, 1);
            chk("req_addr", memAddr, a - 32'(lo));
            chk("req_be", {28'd0, memBe}, {28'd0, ebe});
            chk("req_we", {31'd0, memWe}, {31'd0, wr});
            if (wr) chk("req_wdata", memWdata, ewd);
            memAck = i == waits;
            memRdata = i == waits ? rdw : $urandom;
            tick();
        end
        memAck = 0;
        if (!wr) exp_rdata = load_val(wl, sext, lo, rdw);
        chk("done_req", {31'd0, memReq}, 0);
        chk("done_stall", {31'd0, stall}, 0);
        chk("done_rdata", rdata, exp_rdata);
        memAck = 1;
        tick();
        memAck = 0;
        chk("back_idle_req", {31'd0, memReq}, 0);
        chk("back_idle_rdata", rdata, exp_rdata);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_req", {31'd0, memReq}, 0);
        chk("rst_we", {31'd0, memWe}, 0);
        chk("rst_be", {28'd0, memBe}, 0);
        chk("rst_addr", memAddr, 0);
        chk("rst_wdata", memWdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_misalign", {31'd0, misalign}, 0);
        chk("rst_stall", {31'd0, stall}, 0);
        rst_n = 1;
        tick();
        access(1, 0, 0, 1, 32'h103, 0, 0, 32'h80AABBCC);
        chk("lb_sext", rdata, 32'hFFFFFF80);
        access(0, 1, 1, 0, 32'h22, 32'h1234ABCD, 1, 32'h0);
        chk("sh_keep_rdata", rdata, 32'hFFFFFF80);
        access(1, 0, 2, 0, 32'h40, 0, 3, 32'hDEADBEEF);
        chk("lw_wait", rdata, 32'hDEADBEEF);
        access(1, 0, 2, 0, 32'h41, 0, 0, 0);
        access(1, 1, 2, 0, 32'h80, 32'h55AA55AA, 0, 32'h11111111);
        access(1, 0, 1, 0, 32'h2, 0, 0, 32'h8001FFFF);
        chk("lh_zext", rdata, 32'h00008001);
        // reset while the bus request is outstanding, then a stale ack
        memRead = 1; WL = 2; addr = 32'h200;
        tick();
        memRead = 0;
        chk("mid_req", {31'd0, memReq}, 1);
        rst_n = 0;
        tick();
        rst_n = 1;
        memAck = 1;
        memRdata = 32'hCAFEF00D;
        chk("mid_rst_req", {31'd0, memReq}, 0);
        chk("mid_rst_rdata", rdata, 0);
        tick();
        memAck = 0;
        exp_rdata = 0;
        chk("stale_ack_req", {31'd0, memReq}, 0);
        chk("stale_ack_stall", {31'd0, stall}, 0);
        chk("stale_ack_rdata", rdata, 0);
        for (int k = 0; k < 200; k++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(0, 7);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'h3 | 32'($urandom_range(0, 3)) & (r[0] ? 32'h3 : 32'h2);
            access(r < 4, r >= 3 && r < 7, $urandom_range(0, 3), 1'($urandom), a, $urandom,
                   $urandom_range(0, 3), $urandom);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port memRead, input, 1 bit: the current instruction is a load.
REQ-004 SHALL have port memWrite, input, 1 bit: the current instruction is a store.
REQ-005 SHALL have port WL, input, 2 bits: access width; 0 = byte, 1 = half, 2 = word, 3 = treated as word.
REQ-006 SHALL have port extendSign, input, 1 bit: on loads, 1 = sign-extend, 0 = zero-extend.
REQ-007 SHALL have port addr, input, 32 bits: byte address from the ALU.
REQ-008 SHALL have port wdata, input, 32 bits: store data; only the low WL-sized bits are used.
REQ-009 SHALL have port rdata, output, 32 bits: extended load result.
REQ-010 SHALL have port stall, output, 1 bit: pipeline hold request.
REQ-011 SHALL have port misalign, output, 1 bit: one-cycle misaligned-access flag.
REQ-012 SHALL have port memReq, output, 1 bit: bus request.
REQ-013 SHALL have port memWe, output, 1 bit: bus write enable.
REQ-014 SHALL have port memAddr, output, 32 bits: word-aligned bus address, with [1:0] = 0.
REQ-015 SHALL have port memBe, output, 4 bits: bus byte enables.
REQ-016 SHALL have port memWdata, output, 32 bits: lane-positioned store data.
REQ-017 SHALL have port memRdata, input, 32 bits: bus read word, valid when memAck = 1.
REQ-018 SHALL have port memAck, input, 1 bit: bus completion, sampled only in state REQ.

Function
REQ-019 SHALL implement states IDLE, REQ and DONE.
REQ-020 SHALL define an access as aligned when: WL = 0; or WL = 1 and addr[0] = 0; or WL >= 2 and addr[1:0] = 0.
REQ-021 SHALL, in IDLE with memWrite or memRead high and the access aligned, latch addr, WL, extendSign, wdata and the direction, then go to REQ on the next edge; memWrite has priority when both are high.
REQ-022 SHALL, in IDLE with a misaligned access, register misalign = 1 for exactly one cycle, issue no bus request, keep stall = 0, and stay in IDLE.
REQ-023 SHALL hold memReq = 1 and all bus outputs stable, from the latched values, for every cycle in REQ until memAck = 1.
REQ-024 SHALL, on memAck = 1 in REQ, register rdata (loads only) and move to DONE; memAck in the first REQ cycle is legal.
REQ-025 SHALL spend exactly one cycle in DONE with memReq = 0, then return to IDLE without sampling memRead or memWrite during DONE.
REQ-026 SHALL drive stall combinationally as (IDLE and aligned (memRead or memWrite)) or REQ; stall SHALL be 0 in DONE.
REQ-027 SHALL give a minimum access latency of 2 cycles: request seen in cycle T, memReq and memAck in T+1, DONE with rdata valid and stall = 0 in T+2.
REQ-028 SHALL set memAddr = {addr[31:2], 2'b00}.
REQ-029 SHALL set memBe for stores to 0001 << addr[1:0] (byte), 0011 << (2 * addr[1]) (half), or 1111 (word).
REQ-030 SHALL set memBe = 1111 for loads.
REQ-031 SHALL set memWdata to wdata[7:0] replicated 4 times (byte), wdata[15:0] replicated 2 times (half), or wdata (word).
REQ-032 SHALL form load results as follows:
- byte: lane = memRdata[8*addr[1:0] +: 8];
- half: lane = memRdata[16*addr[1] +: 16];
- the lane is extended to 32 bits according to extendSign;
- word: memRdata unchanged.
REQ-033 SHALL hold rdata from DONE until the next load completes; stores SHALL NOT modify rdata.
REQ-034 SHALL ignore memAck in IDLE and DONE.

Reset
REQ-035 SHALL, while rst_n = 0 at a rising edge, force:
- state = IDLE;
- memReq = 0, memWe = 0, memBe = 0, memAddr = 0, memWdata = 0;
- rdata = 0, misalign = 0.
REQ-036 SHALL, on reset during REQ, abandon the outstanding access; a memAck arriving after reset SHALL be ignored.

Verification
REQ-037 Load byte, sign-extended:
- stimulus: memRead = 1, WL = 0, extendSign = 1, addr = 0x103; memAck in the first REQ cycle with memRdata = 0x80AABBCC;
- response: memAddr = 0x100, memBe = 1111, rdata = 0xFFFFFF80 in DONE, stall pattern 1, 1, 0.
REQ-038 Store half:
- stimulus: memWrite = 1, WL = 1, addr = 0x22, wdata = 0x1234ABCD;
- response: memAddr = 0x20, memBe = 1100, memWdata = 0xABCDABCD, memWe = 1, rdata unchanged.
REQ-039 Bus wait states:
- stimulus: load word at 0x40 with memAck delayed 3 cycles, memRdata = 0xDEADBEEF;
- response: memReq and bus outputs stable for 3 cycles, stall = 1 throughout, rdata = 0xDEADBEEF in DONE.
REQ-040 Misaligned word:
- stimulus: memRead = 1, WL = 2, addr = 0x41;
- response: misalign = 1 for one cycle, memReq stays 0, stall = 0, state stays IDLE.
REQ-041 Reset mid-access:
- stimulus: rst_n = 0 for one edge during REQ, then memAck = 1 in IDLE;
- response: memReq = 0 on the next cycle, no transition to DONE, rdata = 0.
REQ-042 Simultaneous read/write plus zero-extend:
- stimulus: memRead = memWrite = 1 -> response: write performed (memWe = 1);
- stimulus: then a halfword load with extendSign = 0 at 0x2, memRdata = 0x8001FFFF -> response: rdata = 0x00008001.
